// File: rtl/led_output_pkg.sv
// -----------------------------------------------------------------------------
// led_output_pkg
// Shared definitions for the LED output peripheral: channel mode encodings,
// Avalon word addresses, the ID constant and the bit positions of the fields
// in channel writes and channel readbacks.
// No ports (package).
// -----------------------------------------------------------------------------
package led_output_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_COUNT = 2'd3
  } led_mode_t;

  localparam logic [3:0]  ADDR_ID      = 4'd0;
  localparam logic [3:0]  ADDR_CH_BASE = 4'd1;
  localparam logic [3:0]  ADDR_ALL     = 4'd5;

  localparam logic [31:0] ID_VALUE     = 32'd65;

  // Field offsets inside a channel write word.
  localparam int WD_MODE_LSB = 0;
  localparam int WD_HP_LSB   = 8;
  localparam int WD_CNT_LSB  = 16;

  // Field offsets inside a channel readback word.
  localparam int RD_LEVEL_BIT = 0;
  localparam int RD_MODE_LSB  = 1;
  localparam int RD_HP_LSB    = 8;
  localparam int RD_REM_LSB   = 16;

  // Assemble the readback word of one channel.
  function automatic logic [31:0] pack_channel(input logic       level,
                                               input logic [1:0] mode,
                                               input logic [7:0] hp,
                                               input logic [7:0] remaining);
    logic [31:0] w;
    w = '0;
    w[RD_LEVEL_BIT]       = level;
    w[RD_MODE_LSB +: 2]   = mode;
    w[RD_HP_LSB +: 8]     = hp;
    w[RD_REM_LSB +: 8]    = remaining;
    return w;
  endfunction

endpackage

// File: rtl/led_output_channel.sv
// -----------------------------------------------------------------------------
// led_channel
// State machine for one LED: OFF, ON, continuous BLINK, or COUNT (blink a
// given number of pulses, then drop back to OFF). Advances on the shared tick.
// Ports:
//   csi_clk, rsi_reset_n  clock, asynchronous active-high reset
//   tick                  one-cycle prescaler pulse
//   wr_en                 write strobe for this channel (wins over tick)
//   clr_en                force-to-OFF strobe (wins over tick)
//   wr_mode/wr_hp/wr_cnt  fields of the write word
//   level                 current LED level (before pin polarity)
//   mode/hp/remaining     channel state for readback
// -----------------------------------------------------------------------------
module led_channel
  import led_output_pkg::*;
(
  input  logic       csi_clk,
  input  logic       rsi_reset_n,
  input  logic       tick,
  input  logic       wr_en,
  input  logic       clr_en,
  input  logic [1:0] wr_mode,
  input  logic [7:0] wr_hp,
  input  logic [7:0] wr_cnt,
  output logic       level,
  output logic [1:0] mode,
  output logic [7:0] hp,
  output logic [7:0] remaining
);

  led_mode_t  state;
  logic [7:0] phase;

  assign mode = state;

  // Priority: clear, then write, then tick. A write or clear in a tick cycle
  // therefore swallows that tick for this channel. In COUNT, remaining counts
  // falling toggles; the toggle that takes it to zero also parks the channel
  // in OFF with the level already low.
  always_ff @(posedge csi_clk or posedge rsi_reset_n) begin
    if (rsi_reset_n) begin
      state     <= MODE_OFF;
      level     <= 1'b0;
      phase     <= 8'd0;
      remaining <= 8'd0;
      hp        <= 8'd1;
    end else if (clr_en) begin
      state <= MODE_OFF;
      level <= 1'b0;
    end else if (wr_en) begin
      hp <= (wr_hp == 8'd0) ? 8'd1 : wr_hp;
      case (wr_mode)
        MODE_OFF: begin
          state <= MODE_OFF;
          level <= 1'b0;
        end
        MODE_ON: begin
          state <= MODE_ON;
          level <= 1'b1;
        end
        MODE_BLINK: begin
          state     <= MODE_BLINK;
          level     <= 1'b1;
          phase     <= 8'd0;
          remaining <= wr_cnt;
        end
        default: begin
          phase     <= 8'd0;
          remaining <= wr_cnt;
          if (wr_cnt == 8'd0) begin
            state <= MODE_OFF;
            level <= 1'b0;
          end else begin
            state <= MODE_COUNT;
            level <= 1'b1;
          end
        end
      endcase
    end else if (tick && (state == MODE_BLINK || state == MODE_COUNT)) begin
      if (phase == hp - 8'd1) begin
        phase <= 8'd0;
        level <= ~level;
        if (state == MODE_COUNT && level) begin
          if (remaining == 8'd1) begin
            state     <= MODE_OFF;
            remaining <= 8'd0;
          end else begin
            remaining <= remaining - 8'd1;
          end
        end
      end else begin
        phase <= phase + 8'd1;
      end
    end
  end

endmodule

// File: rtl/led_output.sv
// -----------------------------------------------------------------------------
// led_output
// Avalon-MM slave driving up to four LEDs. Holds the free-running tick
// prescaler, the write decode, the combinational read mux and one led_channel
// per LED.
// Ports:
//   csi_clk, rsi_reset_n   clock, asynchronous active-high reset
//   avs_s0_write/read      single-cycle strobes
//   avs_s0_address         word address (0 ID, 1..4 channels, 5 all)
//   avs_s0_writedata       write data
//   avs_s0_readdata        combinational read data, 0 when not reading
//   out_led                LED pins, polarity set by ACTIVE_LOW
// -----------------------------------------------------------------------------
module led_output
  import led_output_pkg::*;
#(
  parameter int LEN        = 4,
  parameter int TICK_MAX   = 4095,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic           csi_clk,
  input  logic           rsi_reset_n,
  input  logic           avs_s0_write,
  input  logic           avs_s0_read,
  input  logic [3:0]     avs_s0_address,
  input  logic [31:0]    avs_s0_writedata,
  output logic [31:0]    avs_s0_readdata,
  output logic [LEN-1:0] out_led
);

  localparam logic [11:0] TICK_TERM = 12'(TICK_MAX);

  logic [11:0]    prescale;
  logic           tick;
  logic           clr_all;
  logic [LEN-1:0] level;
  logic [1:0]     ch_mode [LEN];
  logic [7:0]     ch_hp   [LEN];
  logic [7:0]     ch_rem  [LEN];
  logic           unused_wd;

  // Writes never resynchronise the prescaler, so the first blink interval
  // after a write can be up to one tick period short.
  always_ff @(posedge csi_clk or posedge rsi_reset_n) begin
    if (rsi_reset_n) begin
      prescale <= 12'd0;
    end else if (tick) begin
      prescale <= 12'd0;
    end else begin
      prescale <= prescale + 12'd1;
    end
  end

  assign tick    = (prescale == TICK_TERM);
  assign clr_all = avs_s0_write && (avs_s0_address == ADDR_ALL);

  assign unused_wd = ^{avs_s0_writedata[31:24], avs_s0_writedata[7:2]};

  generate
    for (genvar gi = 0; gi < LEN; gi++) begin : g_ch
      localparam logic [3:0] CH_ADDR = ADDR_CH_BASE + 4'(gi);
      logic wr_en;
      assign wr_en = avs_s0_write && (avs_s0_address == CH_ADDR);

      led_channel u_ch (
        .csi_clk     (csi_clk),
        .rsi_reset_n (rsi_reset_n),
        .tick        (tick),
        .wr_en       (wr_en),
        .clr_en      (clr_all),
        .wr_mode     (avs_s0_writedata[WD_MODE_LSB +: 2]),
        .wr_hp       (avs_s0_writedata[WD_HP_LSB +: 8]),
        .wr_cnt      (avs_s0_writedata[WD_CNT_LSB +: 8]),
        .level       (level[gi]),
        .mode        (ch_mode[gi]),
        .hp          (ch_hp[gi]),
        .remaining   (ch_rem[gi])
      );
    end
  endgenerate

  // level[] are flop outputs; XOR with a constant keeps out_led glitch-free.
  assign out_led = level ^ {LEN{ACTIVE_LOW}};

  // Zero-wait-state read mux; unmapped addresses and idle bus read 0.
  always_comb begin
    avs_s0_readdata = '0;
    if (avs_s0_read) begin
      if (avs_s0_address == ADDR_ID) begin
        avs_s0_readdata = ID_VALUE;
      end else if (avs_s0_address == ADDR_ALL) begin
        avs_s0_readdata[LEN-1:0] = level;
      end else begin
        for (int i = 0; i < LEN; i++) begin
          if (avs_s0_address == ADDR_CH_BASE + 4'(i)) begin
            avs_s0_readdata = pack_channel(level[i], ch_mode[i], ch_hp[i], ch_rem[i]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_output.sv
// -----------------------------------------------------------------------------
// tb_led_output
// Self-checking bench for led_output with TICK_MAX=3. Two instances share the
// stimulus: one active-high, one active-low. A tick-count reference model
// predicts levels and readback words.
// -----------------------------------------------------------------------------
module tb_led_output;

  localparam int TICK_MAX = 3;

  logic        csi_clk          = 1'b0;
  logic        rsi_reset_n      = 1'b1;
  logic        avs_s0_write     = 1'b0;
  logic        avs_s0_read      = 1'b0;
  logic [3:0]  avs_s0_address   = 4'd0;
  logic [31:0] avs_s0_writedata = 32'd0;
  logic [31:0] rdata_hi, rdata_lo;
  logic [3:0]  led_hi, led_lo;

  int total = 0;
  int bad   = 0;

  always #5 csi_clk = ~csi_clk;

  led_output #(.LEN(4), .TICK_MAX(TICK_MAX), .ACTIVE_LOW(1'b0)) dut (
    .csi_clk(csi_clk), .rsi_reset_n(rsi_reset_n),
    .avs_s0_write(avs_s0_write), .avs_s0_read(avs_s0_read),
    .avs_s0_address(avs_s0_address), .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_readdata(rdata_hi), .out_led(led_hi)
  );

  led_output #(.LEN(4), .TICK_MAX(TICK_MAX), .ACTIVE_LOW(1'b1)) dut_al (
    .csi_clk(csi_clk), .rsi_reset_n(rsi_reset_n),
    .avs_s0_write(avs_s0_write), .avs_s0_read(avs_s0_read),
    .avs_s0_address(avs_s0_address), .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_readdata(rdata_lo), .out_led(led_lo)
  );

  // Reference model: each blinking channel remembers how many ticks it has
  // accepted since its last start; level and remaining follow from that count.
  int m_mode [4];
  int m_hp   [4];
  int m_cnt  [4];
  int m_rem  [4];
  int m_ticks[4];
  int mk;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = 0; m_hp[i] = 1; m_cnt[i] = 0; m_rem[i] = 0; m_ticks[i] = 0;
    end
    mk = 0;
  endfunction

  function automatic logic model_level(input int i);
    if (m_mode[i] == 0) return 1'b0;
    if (m_mode[i] == 1) return 1'b1;
    return ((m_ticks[i] / m_hp[i]) % 2) == 0;
  endfunction

  function automatic logic [3:0] model_leds();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = model_level(i);
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic rd, input logic [3:0] a);
    int i;
    if (!rd) return 32'd0;
    if (a == 4'd0) return 32'd65;
    if (a == 4'd5) return {28'd0, model_leds()};
    if (a >= 4'd1 && a <= 4'd4) begin
      i = int'(a) - 1;
      return 32'(m_rem[i] * 65536 + m_hp[i] * 256 + m_mode[i] * 2 + int'(model_level(i)));
    end
    return 32'd0;
  endfunction

  function automatic void model_write(input int i, input logic [31:0] wd);
    int md, h, c;
    md = int'(wd[1:0]);
    h  = int'(wd[15:8]);
    c  = int'(wd[23:16]);
    m_hp[i] = (h == 0) ? 1 : h;
    if (md == 0 || md == 1) begin
      m_mode[i] = md;
    end else begin
      m_rem[i] = c;
      m_cnt[i] = c;
      m_ticks[i] = 0;
      m_mode[i] = (md == 3 && c == 0) ? 0 : md;
    end
  endfunction

  function automatic void model_step();
    bit tick;
    int tog;
    tick = (mk % (TICK_MAX + 1)) == TICK_MAX;
    mk++;
    for (int i = 0; i < 4; i++) begin
      if (avs_s0_write && avs_s0_address == 4'd5) begin
        m_mode[i] = 0;
      end else if (avs_s0_write && avs_s0_address == 4'(i + 1)) begin
        model_write(i, avs_s0_writedata);
      end else if (tick && m_mode[i] >= 2) begin
        m_ticks[i]++;
        if (m_mode[i] == 3) begin
          tog = m_ticks[i] / m_hp[i];
          if (tog >= 2 * m_cnt[i] - 1) begin
            m_mode[i] = 0;
            m_rem[i]  = 0;
          end else begin
            m_rem[i] = m_cnt[i] - (tog + 1) / 2;
          end
        end
      end
    end
  endfunction

  always @(posedge csi_clk or posedge rsi_reset_n) begin
    if (rsi_reset_n) model_reset();
    else model_step();
  end

  // Called just after a negedge; returns just after the next negedge.
  task automatic write_now(input logic [3:0] a, input logic [31:0] wd);
    avs_s0_address   = a;
    avs_s0_writedata = wd;
    avs_s0_write     = 1'b1;
    @(negedge csi_clk);
    avs_s0_write     = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rsi_reset_n = 1'b1;
    repeat (2) @(negedge csi_clk);
    #1;
    total++;
    if (led_hi !== 4'h0) begin bad++; $display("[TB] FAIL reset_led got=%h want=0", led_hi); end
    total++;
    if (led_lo !== 4'hF) begin bad++; $display("[TB] FAIL reset_led_al got=%h want=f", led_lo); end
    @(negedge csi_clk);
    rsi_reset_n = 1'b0;
    avs_s0_read = 1'b1;
    for (int a = 1; a <= 4; a++) begin
      avs_s0_address = 4'(a);
      #1;
      total++;
      if (rdata_hi !== 32'h0000_0100) begin
        bad++; $display("[TB] FAIL reset_rd%0d got=%h want=00000100", a, rdata_hi);
      end
      @(negedge csi_clk);
    end
    avs_s0_read = 1'b0;
  endtask

  task automatic test_address_map();
    avs_s0_read = 1'b1; avs_s0_address = 4'd0; #1;
    total++;
    if (rdata_hi !== 32'd65) begin bad++; $display("[TB] FAIL id got=%0d want=65", rdata_hi); end
    avs_s0_read = 1'b0; avs_s0_address = 4'd3; #1;
    total++;
    if (rdata_hi !== 32'd0) begin bad++; $display("[TB] FAIL idle_read got=%h want=0", rdata_hi); end
    avs_s0_read = 1'b1; avs_s0_address = 4'd9; #1;
    total++;
    if (rdata_hi !== 32'd0) begin bad++; $display("[TB] FAIL unmapped_read got=%h want=0", rdata_hi); end
    avs_s0_read = 1'b0;
    @(negedge csi_clk);
    write_now(4'd0, 32'hFFFF_FFFF);
    write_now(4'd9, 32'h0000_0101);
    avs_s0_read = 1'b1; avs_s0_address = 4'd5; #1;
    total++;
    if (rdata_hi !== 32'd0 || led_hi !== 4'h0) begin
      bad++; $display("[TB] FAIL ignored_write rd=%h led=%h want=0/0", rdata_hi, led_hi);
    end
    avs_s0_address = 4'd1; #1;
    total++;
    if (rdata_hi !== 32'h0000_0100) begin
      bad++; $display("[TB] FAIL ignored_write_ch got=%h want=00000100", rdata_hi);
    end
    avs_s0_read = 1'b0;
    @(negedge csi_clk);
  endtask

  task automatic test_on_off();
    write_now(4'd1, 32'h0000_0001);
    #1;
    total++;
    if (led_hi !== 4'b0001) begin bad++; $display("[TB] FAIL on_led got=%b want=0001", led_hi); end
    avs_s0_read = 1'b1; avs_s0_address = 4'd5; #1;
    total++;
    if (rdata_hi !== 32'h1) begin bad++; $display("[TB] FAIL on_levels got=%h want=1", rdata_hi); end
    avs_s0_address = 4'd1; #1;
    total++;
    if (rdata_hi !== 32'h0000_0103) begin bad++; $display("[TB] FAIL on_rd got=%h want=00000103", rdata_hi); end
    avs_s0_read = 1'b0;
    @(negedge csi_clk);
    write_now(4'd1, 32'h0000_0000);
    #1;
    total++;
    if (led_hi !== 4'b0000) begin bad++; $display("[TB] FAIL off_led got=%b want=0000", led_hi); end
  endtask

  task automatic test_blink();
    int runs[$];
    int run_len;
    logic prev;
    write_now(4'd3, 32'h0000_0202);
    run_len = 0;
    prev    = 1'b1;
    for (int c = 0; c < 48; c++) begin
      #1;
      total++;
      if (led_hi !== model_leds()) begin
        bad++; $display("[TB] FAIL blink_c%0d got=%b want=%b", c, led_hi, model_leds());
      end
      if (led_hi[2] !== prev) begin
        runs.push_back(run_len);
        run_len = 0;
        prev = led_hi[2];
      end
      run_len++;
      @(negedge csi_clk);
    end
    total++;
    if (runs.size() < 3) begin
      bad++; $display("[TB] FAIL blink_runs got=%0d want>=3", runs.size());
    end else begin
      total++;
      if (runs[0] < 5 || runs[0] > 8) begin
        bad++; $display("[TB] FAIL blink_first got=%0d want=5..8", runs[0]);
      end
      total++;
      if (runs[1] != 8 || runs[2] != 8) begin
        bad++; $display("[TB] FAIL blink_period got=%0d,%0d want=8,8", runs[1], runs[2]);
      end
    end
    write_now(4'd3, 32'h0000_0000);
    #1;
    total++;
    if (led_hi[2] !== 1'b0) begin bad++; $display("[TB] FAIL blink_off got=%b want=0", led_hi[2]); end
  endtask

  task automatic test_count();
    int pulses;
    logic prev;
    write_now(4'd4, 32'h0003_0103);
    pulses = 0;
    prev   = 1'b0;
    for (int c = 0; c < 24; c++) begin
      #1;
      total++;
      if (led_hi !== model_leds()) begin
        bad++; $display("[TB] FAIL count_c%0d got=%b want=%b", c, led_hi, model_leds());
      end
      if (led_hi[3] && !prev) pulses++;
      prev = led_hi[3];
      @(negedge csi_clk);
    end
    total++;
    if (pulses != 3) begin bad++; $display("[TB] FAIL count_pulses got=%0d want=3", pulses); end
    avs_s0_read = 1'b1; avs_s0_address = 4'd4; #1;
    total++;
    if (rdata_hi !== 32'h0000_0100) begin
      bad++; $display("[TB] FAIL count_done_rd got=%h want=00000100", rdata_hi);
    end
    avs_s0_read = 1'b0;
    @(negedge csi_clk);
    write_now(4'd2, 32'h0005_0003 & 32'h0000_0003);
    #1;
    avs_s0_read = 1'b1; avs_s0_address = 4'd2; #1;
    total++;
    if (rdata_hi !== 32'h0000_0100 || led_hi[1] !== 1'b0) begin
      bad++; $display("[TB] FAIL count_zero rd=%h led=%b want=00000100/0", rdata_hi, led_hi[1]);
    end
    avs_s0_read = 1'b0;
    @(negedge csi_clk);
  endtask

  task automatic test_tick_collision();
    logic [3:0] prev;
    for (int a = 1; a <= 4; a++) write_now(4'(a), 32'h0000_0102);
    for (int n = 0; n < 8 && (mk % (TICK_MAX + 1)) != TICK_MAX; n++) @(negedge csi_clk);
    total++;
    if ((mk % (TICK_MAX + 1)) != TICK_MAX) begin
      bad++; $display("[TB] FAIL collide_slot got=%0d want=%0d", mk % (TICK_MAX + 1), TICK_MAX);
    end
    prev = model_leds();
    write_now(4'd1, 32'h0000_0102);
    #1;
    total++;
    if (led_hi !== {~prev[3:1], 1'b1}) begin
      bad++; $display("[TB] FAIL collide_led got=%b want=%b", led_hi, {~prev[3:1], 1'b1});
    end
    @(negedge csi_clk);
    for (int c = 0; c < 6; c++) begin
      #1;
      total++;
      if (led_hi !== model_leds()) begin
        bad++; $display("[TB] FAIL collide_c%0d got=%b want=%b", c, led_hi, model_leds());
      end
      @(negedge csi_clk);
    end
    for (int n = 0; n < 8 && (mk % (TICK_MAX + 1)) != TICK_MAX; n++) @(negedge csi_clk);
    write_now(4'd5, 32'h0);
    #1;
    total++;
    if (led_hi !== 4'h0 || led_lo !== 4'hF) begin
      bad++; $display("[TB] FAIL clear_all got=%b/%b want=0000/1111", led_hi, led_lo);
    end
    @(negedge csi_clk);
  endtask

  task automatic test_random();
    logic [31:0] r;
    int sel;
    for (int c = 0; c < 400; c++) begin
      avs_s0_write = ($urandom_range(0, 7) == 0);
      sel = int'($urandom_range(0, 9));
      avs_s0_address = (sel < 6) ? 4'(sel % 4 + 1) : 4'($urandom_range(0, 15));
      r = $urandom();
      r[15:8]  = 8'($urandom_range(0, 3));
      r[23:16] = 8'($urandom_range(0, 3));
      avs_s0_writedata = r;
      avs_s0_read = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (led_hi !== model_leds() || led_lo !== ~model_leds()) begin
        bad++; $display("[TB] FAIL rand_led_c%0d got=%b/%b want=%b", c, led_hi, led_lo, model_leds());
      end
      total++;
      if (rdata_hi !== model_read(avs_s0_read, avs_s0_address) ||
          rdata_lo !== model_read(avs_s0_read, avs_s0_address)) begin
        bad++; $display("[TB] FAIL rand_rd_c%0d a=%0d got=%h/%h want=%h", c, avs_s0_address,
                        rdata_hi, rdata_lo, model_read(avs_s0_read, avs_s0_address));
      end
      @(negedge csi_clk);
    end
    avs_s0_write = 1'b0;
    avs_s0_read  = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    write_now(4'd4, 32'h0005_0203);
    repeat (6) @(negedge csi_clk);
    #2;
    rsi_reset_n = 1'b1;
    #1;
    total++;
    if (led_hi !== 4'h0 || led_lo !== 4'hF) begin
      bad++; $display("[TB] FAIL reset_mid got=%b/%b want=0000/1111", led_hi, led_lo);
    end
    repeat (3) @(negedge csi_clk);
    rsi_reset_n = 1'b0;
    avs_s0_read = 1'b1;
    for (int a = 0; a <= 5; a++) begin
      avs_s0_address = 4'(a);
      #1;
      total++;
      if (rdata_hi !== ((a == 0) ? 32'd65 : (a == 5) ? 32'd0 : 32'h0000_0100)) begin
        bad++; $display("[TB] FAIL reset_mid_rd%0d got=%h", a, rdata_hi);
      end
      @(negedge csi_clk);
    end
    avs_s0_read = 1'b0;
    repeat (12) @(negedge csi_clk);
    #1;
    total++;
    if (led_hi !== 4'h0) begin bad++; $display("[TB] FAIL reset_residual got=%b want=0000", led_hi); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_address_map();
    test_on_off();
    test_blink();
    test_count();
    test_tick_collision();
    test_random();
    test_reset_mid_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
